vga_scanout: RTL and testbench

- Next-generation display scan-out engine for the LCD path.
- Fully parametrised timing generator (porches, pulses, sync polarity, colour depth) combined with a pixel-consumer stage.
- Pops pixels from a show-ahead (FWFT) pixel FIFO, filled by the Wishbone reader on the other side of the FIFO.
- Adds what the previous generation lacked: a start-up fill handshake, frame-aligned start, underflow detection with recovery, and frame/line strobes for the writer side.

---
 rtl/vga_scanout.sv | 207 ++++++++++++++++++++
 tb/tb_vga_scanout.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout -- display scan-out engine for the LCD path.
//
// A free-running raster timing generator (front porch, sync pulse, back porch,
// then active region, on both axes) plus a pixel consumer. The consumer pops a
// show-ahead pixel FIFO during active pixels once the FIFO has been pre-filled
// and a frame boundary has been reached. It reports underflow and recovers at
// the next frame boundary.
//
// Ports:
//   pixel_clk      pixel clock, the only clock
//   pixel_rst_n    asynchronous active-low reset
//   enable         scan-out enable; low forces the consumer back to FILL
//   fifo_rdata     FIFO head word (show-ahead)
//   fifo_empty     FIFO empty
//   fifo_ready     FIFO level at or above the start threshold
//   fifo_rd        pop the FIFO head this cycle (combinational)
//   HS, VS         sync outputs, polarity set by HS_POL / VS_POL
//   BLANK          1 = active pixel, 0 = blanking
//   RGB            pixel data, aligned with BLANK / pixel_x / pixel_y
//   pixel_x/y      active column/row, held outside the active region
//   frame_start    one-cycle pulse registered from the last clock of a frame
//   underflow      sticky underflow flag; underflow_clr clears it
//   underflow_clr  clear request; a simultaneous new underflow wins
module vga_scanout #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int RGB_W  = 24,
    parameter logic [RGB_W-1:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst_n,
    input  logic                       enable,
    input  logic [RGB_W-1:0]           fifo_rdata,
    input  logic                       fifo_empty,
    input  logic                       fifo_ready,
    output logic                       fifo_rd,
    output logic                       HS,
    output logic                       VS,
    output logic                       BLANK,
    output logic [RGB_W-1:0]           RGB,
    output logic [$clog2(HDISP)-1:0]   pixel_x,
    output logic [$clog2(VDISP)-1:0]   pixel_y,
    output logic                       frame_start,
    output logic                       underflow,
    input  logic                       underflow_clr
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HBLANK = HTOTAL - HDISP;
    localparam int VBLANK = VTOTAL - VDISP;
    localparam int HCW    = $clog2(HTOTAL) + 1;
    localparam int VCW    = $clog2(VTOTAL) + 1;
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    localparam logic [HCW-1:0] H_LAST   = HCW'(HTOTAL - 1);
    localparam logic [HCW-1:0] H_PS     = HCW'(HFP);
    localparam logic [HCW-1:0] H_PE     = HCW'(HFP + HPULSE);
    localparam logic [HCW-1:0] H_ACT    = HCW'(HBLANK);
    localparam logic [VCW-1:0] V_LAST   = VCW'(VTOTAL - 1);
    localparam logic [VCW-1:0] V_PS     = VCW'(VFP);
    localparam logic [VCW-1:0] V_PE     = VCW'(VFP + VPULSE);
    localparam logic [VCW-1:0] V_ACT    = VCW'(VBLANK);
    localparam logic           HS_ON    = 1'(HS_POL);
    localparam logic           VS_ON    = 1'(VS_POL);

    typedef enum logic [1:0] {FILL, ALIGN, RUN, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [HCW-1:0]     h_cnt_reg;
    logic [VCW-1:0]     v_cnt_reg;
    logic               hs_reg, vs_reg, blank_reg, frame_start_reg, underflow_reg;
    logic [RGB_W-1:0]   rgb_reg, rgb_next;
    logic [XW-1:0]      pixel_x_reg;
    logic [YW-1:0]      pixel_y_reg;
    logic               hs_act, vs_act, active, h_last, eof;
    logic               rd_next, underflow_set;

    // Raster counters run regardless of enable or consumer state.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_last) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VCW'(1);
        end else begin
            h_cnt_reg <= h_cnt_reg + HCW'(1);
        end
    end

    assign h_last = (h_cnt_reg == H_LAST);
    assign eof    = h_last && (v_cnt_reg == V_LAST);
    assign hs_act = (h_cnt_reg >= H_PS) && (h_cnt_reg < H_PE);
    assign vs_act = (v_cnt_reg >= V_PS) && (v_cnt_reg < V_PE);
    assign active = (h_cnt_reg >= H_ACT) && (v_cnt_reg >= V_ACT);

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Consumer: FILL waits for the pre-fill, ALIGN waits for the frame boundary
    // so the first pop is pixel (0,0), RUN streams, DRAIN discards whatever is
    // left of the broken frame until the writer restarts at frame_start.
    always_comb begin
        state_next    = state_reg;
        rd_next       = 1'b0;
        rgb_next      = '0;
        underflow_set = 1'b0;
        case (state_reg)
            FILL: begin
                if (fifo_ready) begin
                    state_next = ALIGN;
                end
            end
            ALIGN: begin
                if (eof) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (active) begin
                    if (!fifo_empty) begin
                        rd_next  = 1'b1;
                        rgb_next = fifo_rdata;
                    end else begin
                        rgb_next      = UNDERFLOW_RGB;
                        underflow_set = 1'b1;
                        state_next    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                rd_next = !fifo_empty;
                if (active) begin
                    rgb_next = UNDERFLOW_RGB;
                end
                if (eof) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
        // Disabling overrides everything in the same cycle.
        if (!enable) begin
            state_next    = FILL;
            rd_next       = 1'b0;
            rgb_next      = '0;
            underflow_set = 1'b0;
        end
    end

    assign fifo_rd = rd_next;

    // Video outputs are registered one cycle behind the counters.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hs_reg          <= ~HS_ON;
            vs_reg          <= ~VS_ON;
            blank_reg       <= 1'b0;
            rgb_reg         <= '0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            hs_reg          <= hs_act ? HS_ON : ~HS_ON;
            vs_reg          <= vs_act ? VS_ON : ~VS_ON;
            blank_reg       <= active;
            rgb_reg         <= rgb_next;
            frame_start_reg <= eof;
            if (active) begin
                pixel_x_reg <= XW'(h_cnt_reg - H_ACT);
                pixel_y_reg <= YW'(v_cnt_reg - V_ACT);
            end
            // A fresh underflow beats a simultaneous clear.
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end else if (underflow_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign HS          = hs_reg;
    assign VS          = vs_reg;
    assign BLANK       = blank_reg;
    assign RGB         = rgb_reg;
    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout. Two instances share clock and reset: a small
// 16x8 raster with HS_POL=1 that exercises the full pixel path against a FIFO
// queue model, and an asymmetric-porch raster kept disabled that only checks
// the timing outputs. Expected values come from raster arithmetic on a
// cycle index plus a frame-level model of when pixels are consumed.
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int HT = 22, VT = 14, HB = 6, VB = 6, FRAME = HT * VT;
    localparam int HT2 = 14, VT2 = 10, HB2 = 9, VB2 = 6, FRAME2 = HT2 * VT2;
    localparam logic [23:0] UF = 24'hFF00FF;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] fifo_rdata = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_ready = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        fifo_rd, HS, VS, BLANK, frame_start, underflow;
    logic [23:0] RGB;
    logic [3:0]  pixel_x;
    logic [2:0]  pixel_y;

    logic        off_bit = 1'b0;
    logic        on_bit = 1'b1;
    logic [7:0]  zero8 = '0;
    logic        fifo_rd2, HS2, VS2, BLANK2, frame_start2, underflow2;
    logic [7:0]  RGB2;
    logic [2:0]  pixel_x2;
    logic [1:0]  pixel_y2;

    vga_scanout #(
        .HDISP(16), .VDISP(8), .HFP(2), .HPULSE(2), .HBP(2),
        .VFP(2), .VPULSE(2), .VBP(2), .HS_POL(1), .VS_POL(0),
        .RGB_W(24), .UNDERFLOW_RGB(24'hFF00FF)
    ) u_dut (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(enable),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ready(fifo_ready),
        .fifo_rd(fifo_rd), .HS(HS), .VS(VS), .BLANK(BLANK), .RGB(RGB),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    vga_scanout #(
        .HDISP(5), .VDISP(4), .HFP(3), .HPULSE(2), .HBP(4),
        .VFP(1), .VPULSE(2), .VBP(3), .HS_POL(0), .VS_POL(1),
        .RGB_W(8), .UNDERFLOW_RGB(8'hE3)
    ) u_dut2 (
        .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(off_bit),
        .fifo_rdata(zero8), .fifo_empty(on_bit), .fifo_ready(off_bit),
        .fifo_rd(fifo_rd2), .HS(HS2), .VS(VS2), .BLANK(BLANK2), .RGB(RGB2),
        .pixel_x(pixel_x2), .pixel_y(pixel_y2), .frame_start(frame_start2),
        .underflow(underflow2), .underflow_clr(off_bit)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef enum int {M_IDLE, M_ARMED, M_STREAM, M_DRAIN} mode_t;

    int          n_cmp = 0, n_bad = 0;
    int          p = 0, cyc = 0;
    mode_t       mode = M_IDLE;
    logic [23:0] q[$];
    bit          keep_full = 1'b0;
    int          mx = 0, my = 0, mx2 = 0, my2 = 0;
    bit          muf = 1'b0;
    bit          last_rd = 1'b0;
    int          st_rd, st_first_h, st_first_v, st_blank, st_hs_on, st_vs_lo, st_fs, st_uf;
    int          fs_times[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h at t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    function automatic bit in_rng(input int x, input int lo, input int n);
        return (x >= lo) && (x < lo + n);
    endfunction

    function automatic logic [23:0] rand_px();
        // bit 23 cleared so streamed data never looks like the underflow colour
        return 24'($urandom) & 24'h7FFFFF;
    endfunction

    task automatic clear_stats();
        st_rd = 0; st_first_h = -1; st_first_v = -1; st_blank = 0;
        st_hs_on = 0; st_vs_lo = 0; st_fs = 0; st_uf = 0;
    endtask

    task automatic model_reset();
        p = 0; mode = M_IDLE; mx = 0; my = 0; mx2 = 0; my2 = 0; muf = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, ".HS"}, 32'(HS), 32'd0);
        chk({tag, ".VS"}, 32'(VS), 32'd1);
        chk({tag, ".BLANK"}, 32'(BLANK), 32'd0);
        chk({tag, ".RGB"}, 32'(RGB), 32'd0);
        chk({tag, ".pixel_x"}, 32'(pixel_x), 32'd0);
        chk({tag, ".pixel_y"}, 32'(pixel_y), 32'd0);
        chk({tag, ".frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, ".underflow"}, 32'(underflow), 32'd0);
        chk({tag, ".fifo_rd"}, 32'(fifo_rd), 32'd0);
        chk({tag, ".HS2"}, 32'(HS2), 32'd1);
        chk({tag, ".VS2"}, 32'(VS2), 32'd0);
        chk({tag, ".BLANK2"}, 32'(BLANK2), 32'd0);
        chk({tag, ".pixel_x2"}, 32'(pixel_x2), 32'd0);
    endtask

    // One pixel clock: drive the FIFO view, check fifo_rd before the edge,
    // then check every registered output just after it.
    task automatic cycle();
        int h, v, h2, v2;
        bit act, act2, eof, exp_rd, set;
        logic [23:0] head, exp_rgb;
        if (keep_full) while (q.size() < 4) q.push_back(rand_px());
        fifo_empty = (q.size() == 0);
        if (fifo_empty) head = rand_px();
        else            head = q[0];
        fifo_rdata = head;
        h = p % HT; v = (p / HT) % VT;
        act = (h >= HB) && (v >= VB);
        eof = (p % FRAME) == FRAME - 1;
        exp_rd = 1'b0; exp_rgb = '0; set = 1'b0;
        if (enable) begin
            if (mode == M_STREAM && act) begin
                if (!fifo_empty) begin exp_rd = 1'b1; exp_rgb = head; end
                else begin exp_rgb = UF; set = 1'b1; end
            end else if (mode == M_DRAIN) begin
                exp_rd = !fifo_empty;
                if (act) exp_rgb = UF;
            end
        end
        @(negedge pixel_clk);
        last_rd = (fifo_rd === 1'b1);
        chk("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        chk("fifo_rd2", 32'(fifo_rd2), 32'd0);
        if (last_rd) begin
            st_rd++;
            if (st_first_h < 0) begin st_first_h = h; st_first_v = v; end
        end
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (exp_rd) void'(q.pop_front());
        if (!enable) mode = M_IDLE;
        else begin
            case (mode)
                M_IDLE:   if (fifo_ready) mode = M_ARMED;
                M_ARMED:  if (eof) mode = M_STREAM;
                M_STREAM: if (set) mode = M_DRAIN;
                default:  if (eof) mode = M_IDLE;
            endcase
        end
        if (act) begin mx = h - HB; my = v - VB; end
        if (set) muf = 1'b1;
        else if (underflow_clr) muf = 1'b0;
        chk("HS", 32'(HS), 32'(in_rng(h, 2, 2)));
        chk("VS", 32'(VS), 32'(!in_rng(v, 2, 2)));
        chk("BLANK", 32'(BLANK), 32'(act));
        chk("RGB", 32'(RGB), 32'(exp_rgb));
        chk("pixel_x", 32'(pixel_x), 32'(mx));
        chk("pixel_y", 32'(pixel_y), 32'(my));
        chk("frame_start", 32'(frame_start), 32'(eof));
        chk("underflow", 32'(underflow), 32'(muf));
        h2 = p % HT2; v2 = (p / HT2) % VT2;
        act2 = (h2 >= HB2) && (v2 >= VB2);
        if (act2) begin mx2 = h2 - HB2; my2 = v2 - VB2; end
        chk("HS2", 32'(HS2), 32'(!in_rng(h2, 3, 2)));
        chk("VS2", 32'(VS2), 32'(in_rng(v2, 1, 2)));
        chk("BLANK2", 32'(BLANK2), 32'(act2));
        chk("pixel_x2", 32'(pixel_x2), 32'(mx2));
        chk("pixel_y2", 32'(pixel_y2), 32'(my2));
        chk("frame_start2", 32'(frame_start2), 32'((p % FRAME2) == FRAME2 - 1));
        chk("RGB2", 32'(RGB2), 32'd0);
        if (BLANK === 1'b1) st_blank++;
        if (HS === 1'b1) st_hs_on++;
        if (VS === 1'b0) st_vs_lo++;
        if (frame_start === 1'b1) begin st_fs++; fs_times.push_back(cyc); end
        if (BLANK === 1'b1 && RGB === UF) st_uf++;
        p++;
    endtask

    task automatic run_frame();
        clear_stats();
        repeat (FRAME) cycle();
    endtask

    task automatic run_until(input int h, input int v);
        int guard = 0;
        while (!((p % HT) == h && ((p / HT) % VT) == v) && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        chk("run_until_reached", 32'(guard < 2 * FRAME), 32'd1);
    endtask

    task automatic finish_frame();
        while ((p % FRAME) != 0) cycle();
    endtask

    initial begin
        // Power-on reset, then release between edges.
        repeat (3) @(posedge pixel_clk);
        #1;
        reset_vals("por");
        #1;
        pixel_rst_n = 1'b1;
        model_reset();

        // Frame 0 with enable low: pure timing.
        run_frame();
        chk("f0_blank_cycles", 32'(st_blank), 32'd128);
        chk("f0_hs_high_cycles", 32'(st_hs_on), 32'd28);
        chk("f0_vs_low_cycles", 32'(st_vs_lo), 32'd44);
        chk("f0_frame_start_count", 32'(st_fs), 32'd1);
        chk("f0_reads", 32'(st_rd), 32'd0);

        // Frame 1: enable with a full FIFO, ready mid-frame; no reads yet.
        enable = 1'b1;
        keep_full = 1'b1;
        clear_stats();
        repeat (150) cycle();
        fifo_ready = 1'b1;
        repeat (FRAME - 150) cycle();
        chk("f1_reads", 32'(st_rd), 32'd0);
        chk("frame_start_period", 32'((fs_times.size() >= 2) ? fs_times[1] - fs_times[0] : -1), 32'(FRAME));

        // Frame 2: streaming starts at pixel (0,0).
        run_frame();
        chk("f2_reads", 32'(st_rd), 32'd128);
        chk("f2_first_h", 32'(st_first_h), 32'(HB));
        chk("f2_first_v", 32'(st_first_v), 32'(VB));

        // Frame 3: FIFO runs dry at pixel (10,3); stale words arrive later.
        clear_stats();
        run_until(HB + 10, VB + 3);
        q.delete();
        keep_full = 1'b0;
        cycle();
        chk("uf_set", 32'(underflow), 32'd1);
        repeat (5) cycle();
        repeat (3) q.push_back(rand_px());
        repeat (10) cycle();
        chk("stale_drained", 32'(q.size()), 32'd0);
        keep_full = 1'b1;
        finish_frame();
        chk("f3_uf_pixels", 32'(st_uf), 32'd70);

        // Frame 4 realigns, frame 5 streams again from (0,0).
        run_frame();
        chk("f4_reads", 32'(st_rd), 32'd0);
        run_frame();
        chk("f5_reads", 32'(st_rd), 32'd128);
        chk("f5_first_h", 32'(st_first_h), 32'(HB));
        chk("f5_first_v", 32'(st_first_v), 32'(VB));

        // Frame 6: clear alone, then clear coinciding with a new underflow.
        underflow_clr = 1'b1;
        cycle();
        underflow_clr = 1'b0;
        chk("uf_clr_alone", 32'(underflow), 32'd0);
        run_until(HB + 3, VB + 2);
        q.delete();
        keep_full = 1'b0;
        underflow_clr = 1'b1;
        cycle();
        underflow_clr = 1'b0;
        keep_full = 1'b1;
        chk("uf_clr_vs_set", 32'(underflow), 32'd1);
        finish_frame();

        // Frame 7 realigns; frame 8 streams and is disabled mid-line.
        run_frame();
        run_until(HB + 5, VB + 4);
        enable = 1'b0;
        cycle();
        chk("disable_rd", 32'(last_rd), 32'd0);
        chk("disable_rgb", 32'(RGB), 32'd0);
        chk("disable_blank", 32'(BLANK), 32'd1);
        repeat (HT) cycle();

        // Asynchronous reset in the middle of an active line.
        enable = 1'b1;
        run_until(HB + 2, VB + 1);
        cycle();
        #2;
        pixel_rst_n = 1'b0;
        #1;
        reset_vals("async");
        repeat (2) @(posedge pixel_clk);
        #2;
        pixel_rst_n = 1'b1;
        model_reset();
        run_frame();
        chk("post_rst_f0_reads", 32'(st_rd), 32'd0);
        run_frame();
        chk("post_rst_f1_reads", 32'(st_rd), 32'd128);
        chk("post_rst_first_h", 32'(st_first_h), 32'(HB));
        chk("post_rst_first_v", 32'(st_first_v), 32'(VB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
